// File: rtl/sfp_pkg.sv
// sfp_pkg: saturation limits and lane-packing helper for signed fixed-point vector blocks
package sfp_pkg;
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction
  function automatic logic [63:0] sat_min(input int w);
    return 64'd1 << (w - 1);
  endfunction
  function automatic int lane_lsb(input int i, input int w);
    return i * w;
  endfunction
endpackage

// File: rtl/sfp_lane_fma.sv
// sfp_lane_fma: one lane of P = O + t*D, two register stages with overflow detection
module sfp_lane_fma
  import sfp_pkg::*;
#(
  parameter int IW = 8,
  parameter int QW = 16,
  parameter int CLIP = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ld1,
  input  logic               ld2,
  input  logic [IW+QW-1:0]   t,
  input  logic [IW+QW-1:0]   d,
  input  logic [IW+QW-1:0]   o,
  output logic [IW+QW-1:0]   p,
  output logic               ov
);
  localparam int W = IW + QW;
  localparam logic [W-1:0] SMAX = W'(sat_max(W));
  localparam logic [W-1:0] SMIN = W'(sat_min(W));
  logic signed [2*W-1:0] prod;
  logic [IW:0] hi;
  logic [W-1:0] m, m_q, o_q, pn;
  logic [W:0] sum;
  logic ov1, ov1_q, ov2, unused_lo;
  assign prod = $signed({{W{t[W-1]}}, t}) * $signed({{W{d[W-1]}}, d});
  assign hi = prod[2*W-1:QW+W-1];
  assign unused_lo = ^prod[QW-1:0];
  assign ov1 = !(&hi || !(|hi));
  assign m = (ov1 && CLIP != 0) ? (prod[2*W-1] ? SMIN : SMAX) : prod[QW+W-1:QW];
  assign sum = {o_q[W-1], o_q} + {m_q[W-1], m_q};
  assign ov2 = sum[W] ^ sum[W-1];
  assign pn = (ov2 && CLIP != 0) ? (sum[W] ? SMIN : SMAX) : sum[W-1:0];
  // stage 1 holds the scaled product and origin; stage 2 holds the final point and flag
  always_ff @(posedge clk) begin
    if (rst) begin
      m_q <= '0;
      o_q <= '0;
      ov1_q <= 1'b0;
      p <= '0;
      ov <= 1'b0;
    end else begin
      if (ld1) begin
        m_q <= m;
        o_q <= o;
        ov1_q <= ov1;
      end
      if (ld2) begin
        p <= pn;
        ov <= ov1_q | ov2;
      end
    end
  end
endmodule

// File: rtl/sfp_ray_at_pipe.sv
// sfp_ray_at_pipe: pipelined ray point P = O + t*D over N lanes; SFP_RAY_AT_STICKY_EN adds sticky clip flags
module sfp_ray_at_pipe
  import sfp_pkg::*;
#(
  parameter int N = 3,
  parameter int IW = 8,
  parameter int QW = 16,
  parameter int CLIP = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N*(IW+QW)-1:0]   orig,
  input  logic [N*(IW+QW)-1:0]   dir,
  input  logic [IW+QW-1:0]       t,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N*(IW+QW)-1:0]   point,
  output logic [N-1:0]           clip
`ifdef SFP_RAY_AT_STICKY_EN
  ,
  output logic [N-1:0]           clip_sticky,
  input  logic                   clip_clr
`endif
);
  localparam int W = IW + QW;
  logic v1, v2, en, acc;
  assign en = !v2 || out_ready;
  assign in_ready = en || rst;
  assign acc = in_valid && in_ready;
  assign out_valid = v2;
  // both stages advance together whenever the output slot is free or being drained
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else if (en) begin
      v1 <= in_valid;
      v2 <= v1;
    end
  end
  for (genvar i = 0; i < N; i++) begin : g_lane
    sfp_lane_fma #(.IW(IW), .QW(QW), .CLIP(CLIP)) u_lane (
      .clk(clk),
      .rst(rst),
      .ld1(acc),
      .ld2(en && v1),
      .t(t),
      .d(dir[lane_lsb(i, W) +: W]),
      .o(orig[lane_lsb(i, W) +: W]),
      .p(point[lane_lsb(i, W) +: W]),
      .ov(clip[i])
    );
  end
`ifdef SFP_RAY_AT_STICKY_EN
  // accumulate flags of transferred results; a new set outranks a clear
  always_ff @(posedge clk) begin
    if (rst) clip_sticky <= '0;
    else clip_sticky <= (clip_clr ? '0 : clip_sticky) | ((v2 && out_ready) ? clip : '0);
  end
`endif
endmodule

// File: tb/tb_sfp_ray_at_pipe.sv
// tb_sfp_ray_at_pipe: scoreboard bench for sfp_ray_at_pipe, CLIP=1 and CLIP=0 instances side by side
module tb_sfp_ray_at_pipe;
  logic clk = 1'b0;
  logic rst, in_valid, out_ready, clip_clr;
  logic [71:0] orig, dir;
  logic [23:0] t;
  logic rdy1, ov1, rdy0, ov0;
  logic [71:0] pt1, pt0;
  logic [2:0] cl1, cl0, st1, st0;
  always #5 clk = ~clk;

  sfp_ray_at_pipe #(.N(3), .IW(8), .QW(16), .CLIP(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .orig(orig), .dir(dir), .t(t),
    .out_valid(ov1), .out_ready(out_ready), .point(pt1), .clip(cl1)
`ifdef SFP_RAY_AT_STICKY_EN
    , .clip_sticky(st1), .clip_clr(clip_clr)
`endif
  );
  sfp_ray_at_pipe #(.N(3), .IW(8), .QW(16), .CLIP(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .orig(orig), .dir(dir), .t(t),
    .out_valid(ov0), .out_ready(out_ready), .point(pt0), .clip(cl0)
`ifdef SFP_RAY_AT_STICKY_EN
    , .clip_sticky(st0), .clip_clr(clip_clr)
`endif
  );
`ifndef SFP_RAY_AT_STICKY_EN
  assign st1 = '0;
  assign st0 = '0;
`endif

  typedef struct {logic [71:0] p1; logic [2:0] c1; logic [71:0] p0; logic [2:0] c0;} exp_t;
  typedef struct {logic [71:0] o; logic [71:0] d; logic [23:0] t; exp_t e;} vec_t;
  exp_t q[$];
  vec_t tbl[7];
  exp_t z = '{p1: '0, c1: '0, p0: '0, c0: '0};
  int checks = 0, errors = 0;
  bit stalled = 0, saw_block = 0, tk;
  logic [151:0] hold;

  task automatic chk(input string n, input logic [151:0] a, input logic [151:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, a, e);
    end
  endtask

  function automatic void lane_model(input logic [23:0] o, input logic [23:0] d, input logic [23:0] tt,
                                     input bit cm, output logic [23:0] p, output bit c);
    longint prod, m, s;
    bit a1, a2;
    prod = longint'($signed(tt)) * longint'($signed(d));
    m = prod >>> 16;
    a1 = m > 8388607 || m < -8388608;
    if (a1) m = cm ? (m > 0 ? 64'sd8388607 : -64'sd8388608) : longint'($signed(m[23:0]));
    s = longint'($signed(o)) + m;
    a2 = s > 8388607 || s < -8388608;
    p = (cm && a2) ? (s > 0 ? 24'h7FFFFF : 24'h800000) : s[23:0];
    c = a1 | a2;
  endfunction

  function automatic exp_t model(input logic [71:0] o, input logic [71:0] d, input logic [23:0] tt);
    exp_t r;
    logic [23:0] p;
    bit c;
    for (int i = 0; i < 3; i++) begin
      lane_model(o[i*24 +: 24], d[i*24 +: 24], tt, 1, p, c);
      r.p1[i*24 +: 24] = p;
      r.c1[i] = c;
      lane_model(o[i*24 +: 24], d[i*24 +: 24], tt, 0, p, c);
      r.p0[i*24 +: 24] = p;
      r.c0[i] = c;
    end
    return r;
  endfunction

  function automatic logic [23:0] r24();
    logic [23:0] b;
    b = 24'($urandom);
    return $urandom_range(0, 1) ? b : {{12{b[11]}}, b[11:0]};
  endfunction

  task automatic step(input exp_t e, output bit took);
    #1;
    took = 0;
    if (rst) begin
      chk("in_ready_rst", {rdy1, rdy0}, 2'b11);
      q.delete();
      stalled = 0;
    end else begin
      chk("in_ready", {rdy1, rdy0}, {2{!ov1 || out_ready}});
      if (stalled) chk("hold", {ov1, pt1, cl1, ov0, pt0, cl0}, hold);
      if (ov1 && out_ready) begin
        if (q.size() == 0) chk("spurious", ov1, 0);
        else begin
          exp_t x = q.pop_front();
          chk("point_clip1", pt1, x.p1);
          chk("clip_clip1", cl1, x.c1);
          chk("point_clip0", pt0, x.p0);
          chk("clip_clip0", cl0, x.c0);
        end
      end
      stalled = ov1 && !out_ready;
      hold = {ov1, pt1, cl1, ov0, pt0, cl0};
      if (in_valid && !rdy1) saw_block = 1;
      if (in_valid && rdy1) begin
        q.push_back(e);
        took = 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    in_valid = 0;
    out_ready = 1;
    for (int k = 0; k < 20 && q.size() > 0; k++) step(z, tk);
    chk("drain", q.size(), 0);
  endtask

  task automatic apply(input vec_t v);
    orig = v.o;
    dir = v.d;
    t = v.t;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{o: {24'h020000, 24'h010000, 24'h000000}, d: {24'h004000, 24'hFF8000, 24'h010000}, t: 24'h020000,
               e: '{p1: {24'h028000, 24'h000000, 24'h020000}, c1: 3'b000, p0: {24'h028000, 24'h000000, 24'h020000}, c0: 3'b000}};
    tbl[1] = '{o: 72'h0, d: {24'h0, 24'h0, 24'h020000}, t: 24'h640000,
               e: '{p1: {24'h0, 24'h0, 24'h7FFFFF}, c1: 3'b001, p0: {24'h0, 24'h0, 24'hC80000}, c0: 3'b001}};
    tbl[2] = '{o: {24'h0, 24'h7F0000, 24'h0}, d: {24'h0, 24'h020000, 24'h0}, t: 24'h010000,
               e: '{p1: {24'h0, 24'h7FFFFF, 24'h0}, c1: 3'b010, p0: {24'h0, 24'h810000, 24'h0}, c0: 3'b010}};
    tbl[3] = '{o: 72'h0, d: {24'hFE0000, 24'h0, 24'h0}, t: 24'h640000,
               e: '{p1: {24'h800000, 24'h0, 24'h0}, c1: 3'b100, p0: {24'h380000, 24'h0, 24'h0}, c0: 3'b100}};
    tbl[4] = '{o: {24'h0, 24'h0, 24'h800000}, d: {24'h0, 24'h0, 24'hFF0000}, t: 24'h010000,
               e: '{p1: {24'h0, 24'h0, 24'h800000}, c1: 3'b001, p0: {24'h0, 24'h0, 24'h7F0000}, c0: 3'b001}};
    tbl[5] = '{o: 72'h0, d: {24'h0, 24'h008000, 24'hFF8000}, t: 24'h000001,
               e: '{p1: {24'h0, 24'h0, 24'hFFFFFF}, c1: 3'b000, p0: {24'h0, 24'h0, 24'hFFFFFF}, c0: 3'b000}};
    tbl[6] = '{o: {24'h0, 24'hF00000, 24'h0}, d: {24'h0, 24'h020000, 24'h0}, t: 24'h640000,
               e: '{p1: {24'h0, 24'h6FFFFF, 24'h0}, c1: 3'b010, p0: {24'h0, 24'hB80000, 24'h0}, c0: 3'b010}};
    rst = 1; in_valid = 0; out_ready = 1; clip_clr = 0; orig = '0; dir = '0; t = '0;
    @(negedge clk);
    step(z, tk);
    step(z, tk);
    rst = 0;
    chk("rst_state", {ov1, pt1, cl1, ov0, pt0, cl0}, '0);
    chk("rst_sticky", {st1, st0}, 6'b0);
    apply(tbl[0]);
    in_valid = 1;
    step(tbl[0].e, tk);
    in_valid = 0;
    chk("latency_1", ov1, 0);
    step(z, tk);
    chk("latency_2", ov1, 1);
    drain();
    in_valid = 1;
    for (int k = 0; k < 7; k++) begin
      apply(tbl[k]);
      step(tbl[k].e, tk);
    end
    drain();
    for (int k = 0; k < 40; k++) begin
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      orig = {r24(), r24(), r24()};
      dir = {r24(), r24(), r24()};
      t = r24();
      step(model(orig, dir, t), tk);
    end
    drain();
    begin
      int sent = 0;
      saw_block = 0;
      for (int k = 0; k < 60 && (sent < 10 || q.size() > 0); k++) begin
        in_valid = sent < 10;
        orig = {3{24'(sent * 24'h012345)}};
        dir = {24'(sent * 24'h003000), 24'hFF0000, 24'(24'h010000 + sent)};
        t = 24'(24'h008000 * sent);
        out_ready = !(k >= 3 && k <= 7);
        step(model(orig, dir, t), tk);
        if (tk) sent++;
      end
      chk("bp_sent", sent, 10);
      chk("bp_blocked", saw_block, 1);
      chk("bp_drain", q.size(), 0);
    end
    out_ready = 0;
    in_valid = 1;
    apply(tbl[1]);
    step(tbl[1].e, tk);
    apply(tbl[2]);
    step(tbl[2].e, tk);
    in_valid = 0;
    rst = 1;
    step(z, tk);
    rst = 0;
    out_ready = 1;
    chk("rst_mid_valid", {ov1, ov0}, 2'b00);
    for (int k = 0; k < 5; k++) begin
      chk("rst_mid_quiet", ov1, 0);
      step(z, tk);
    end
`ifdef SFP_RAY_AT_STICKY_EN
    in_valid = 1;
    apply(tbl[3]);
    step(tbl[3].e, tk);
    apply(tbl[0]);
    step(tbl[0].e, tk);
    step(tbl[0].e, tk);
    drain();
    chk("sticky_keep", {st1, st0}, 6'b100100);
    clip_clr = 1;
    step(z, tk);
    clip_clr = 0;
    chk("sticky_clear", {st1, st0}, 6'b0);
    in_valid = 1;
    apply(tbl[3]);
    step(tbl[3].e, tk);
    in_valid = 0;
    step(z, tk);
    clip_clr = 1;
    step(z, tk);
    clip_clr = 0;
    chk("sticky_set_wins", {st1, st0}, 6'b100100);
    drain();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
